// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit.
// Purpose : entry format for the in-flight branch queue, resolver state
//           encoding, the fall-through increment and the redirect helper.
// Ports   : none (package).
package branch_resolve_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     taken;
  } lc3b_bru_entry;

  localparam lc3b_word BRU_FALLTHROUGH_INC = 16'd2;

  typedef enum logic {
    BRU_RUN,
    BRU_RECOVER
  } lc3b_bru_state;

  // Correct next PC after a resolved branch: the real target when taken,
  // otherwise the instruction after the branch (wraps at 16 bits).
  function automatic lc3b_word bru_redirect(input logic     taken,
                                            input lc3b_word target,
                                            input lc3b_word pc);
    lc3b_word fallthrough;
    fallthrough = pc + BRU_FALLTHROUGH_INC;
    return taken ? target : fallthrough;
  endfunction

endpackage

// File: rtl/bru_queue.sv
// In-order circular FIFO of in-flight branch predictions.
// Purpose : holds {pc, taken} for each predicted branch until it resolves.
// Ports   : clk, reset (async, active-high)
//           i_push / i_push_data : append an entry at the tail
//           i_pop                : retire the head entry
//           i_flush              : retire the head and discard everything else
//           o_head               : current head entry
//           o_count / o_full     : occupancy and full flag
module bru_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  lc3b_bru_entry i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output lc3b_bru_entry o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full
);

  lc3b_bru_entry r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Entry storage carries no reset; the pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      // Flush accompanies the pop of the mispredicted head: everything
      // younger is wrong-path, so the queue collapses to empty just past it.
      r_head  <= r_head + 1'b1;
      r_tail  <= r_head + 1'b1;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: update-side partner of the global BHT.
// Purpose : tracks predictions in order, retires them as branches resolve,
//           drives the BHT update, flags mispredictions with a redirect PC
//           and flush, and counts retired branches and mispredictions.
// Ports   : clk, reset (async, active-high)
//           pred_valid/pred_pc/pred_taken           : prediction from fetch
//           resolve_valid/resolve_taken/resolve_target : oldest branch outcome
//           full                                    : queue full (combinational)
//           bht_write/bht_write_pc/bht_taken        : BHT update, one cycle
//           mispredict/redirect_pc                  : flush pulse + next PC
//           resolve_error                           : resolve with empty queue
//           branch_count/mispredict_count           : statistics
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_valid,
  input  logic [15:0]          pred_pc,
  input  logic                 pred_taken,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  input  logic [15:0]          resolve_target,
  output logic                 full,
  output logic                 bht_write,
  output logic [15:0]          bht_write_pc,
  output logic                 bht_taken,
  output logic                 mispredict,
  output logic [15:0]          redirect_pc,
  output logic                 resolve_error,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  lc3b_bru_state        r_state;
  logic                 r_bht_write;
  lc3b_word             r_bht_write_pc;
  logic                 r_bht_taken;
  logic                 r_mispredict;
  lc3b_word             r_redirect_pc;
  logic                 r_resolve_error;
  logic [CNT_WIDTH-1:0] r_branch_count;
  logic [CNT_WIDTH-1:0] r_mispredict_count;

  lc3b_bru_entry w_head;
  lc3b_bru_entry w_push_data;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_mispredict_now;

  assign w_empty          = (w_count == '0);
  assign w_pop            = resolve_valid && !w_empty;
  assign w_mispredict_now = w_pop && (w_head.taken != resolve_taken);
  // A pop frees a slot in the same cycle, so a push while full is accepted
  // only when paired with a retire. Wrong-path pushes are dropped.
  assign w_push           = pred_valid && (!w_full || w_pop) &&
                            (r_state == BRU_RUN) && !w_mispredict_now;
  assign w_push_data      = '{pc: pred_pc, taken: pred_taken};

  bru_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_mispredict_now),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= BRU_RUN;
      r_bht_write        <= 1'b0;
      r_bht_write_pc     <= '0;
      r_bht_taken        <= 1'b0;
      r_mispredict       <= 1'b0;
      r_redirect_pc      <= '0;
      r_resolve_error    <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      // RECOVER lasts exactly the cycle in which the flush pulse is visible.
      case (r_state)
        BRU_RUN:     r_state <= w_mispredict_now ? BRU_RECOVER : BRU_RUN;
        BRU_RECOVER: r_state <= BRU_RUN;
        default:     r_state <= BRU_RUN;
      endcase

      r_bht_write     <= w_pop;
      r_mispredict    <= w_mispredict_now;
      r_resolve_error <= resolve_valid && w_empty;

      if (w_pop) begin
        r_bht_write_pc <= w_head.pc;
        r_bht_taken    <= resolve_taken;
        r_branch_count <= r_branch_count + 1'b1;
      end

      if (w_mispredict_now) begin
        r_redirect_pc      <= bru_redirect(resolve_taken, resolve_target, w_head.pc);
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  assign full             = w_full;
  assign bht_write        = r_bht_write;
  assign bht_write_pc     = r_bht_write_pc;
  assign bht_taken        = r_bht_taken;
  assign mispredict       = r_mispredict;
  assign redirect_pc      = r_redirect_pc;
  assign resolve_error    = r_resolve_error;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic        pred_valid;
  logic [15:0] pred_pc;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic        full;
  logic        bht_write;
  logic [15:0] bht_write_pc;
  logic        bht_taken;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic        resolve_error;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(
    .DEPTH     (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .full             (full),
    .bht_write        (bht_write),
    .bht_write_pc     (bht_write_pc),
    .bht_taken        (bht_taken),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .resolve_error    (resolve_error),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, then idle the inputs.
  task automatic step(input logic pv, input logic [15:0] ppc, input logic pt,
                      input logic rv, input logic rt, input logic [15:0] rtgt);
    pred_valid     = pv;
    pred_pc        = ppc;
    pred_taken     = pt;
    resolve_valid  = rv;
    resolve_taken  = rt;
    resolve_target = rtgt;
    @(posedge clk);
    #1;
    pred_valid     = 1'b0;
    pred_pc        = 16'h0;
    pred_taken     = 1'b0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = 16'h0;
  endtask

  task automatic push(input logic [15:0] pc, input logic t);
    step(1'b1, pc, t, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic resolve(input logic t, input logic [15:0] tgt);
    step(1'b0, 16'h0, 1'b0, 1'b1, t, tgt);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    reset          = 1'b1;
    pred_valid     = 1'b0;
    pred_pc        = 16'h0;
    pred_taken     = 1'b0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = 16'h0;
    #1;
    check("rst_full",     full,             0);
    check("rst_bhtw",     bht_write,        0);
    check("rst_misp",     mispredict,       0);
    check("rst_redirect", redirect_pc,      0);
    check("rst_bcnt",     branch_count,     0);
    check("rst_mcnt",     mispredict_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Correct prediction
    push(16'h1000, 1'b1);
    check("c_full", full, 0);
    check("c_bhtw_pre", bht_write, 0);
    resolve(1'b1, 16'h1040);
    check("c_bhtw", bht_write, 1);
    check("c_pc", bht_write_pc, 16'h1000);
    check("c_taken", bht_taken, 1);
    check("c_misp", mispredict, 0);
    check("c_bcnt", branch_count, 1);
    check("c_mcnt", mispredict_count, 0);
    idle();
    check("c_bhtw_pulse", bht_write, 0);

    // Not-taken mispredict flushes younger entries; push in detect cycle dropped
    push(16'h2000, 1'b1);
    push(16'h2004, 1'b1);
    push(16'h2008, 1'b0);
    step(1'b1, 16'h2100, 1'b1, 1'b1, 1'b0, 16'h0);
    check("nt_misp", mispredict, 1);
    check("nt_redirect", redirect_pc, 16'h2002);
    check("nt_mcnt", mispredict_count, 1);
    check("nt_bhtw", bht_write, 1);
    check("nt_pc", bht_write_pc, 16'h2000);
    check("nt_taken", bht_taken, 0);
    check("nt_bcnt", branch_count, 2);
    check("nt_full", full, 0);
    push(16'h2200, 1'b1);  // RECOVER cycle: ignored
    check("nt_misp_pulse", mispredict, 0);
    resolve(1'b1, 16'h0);
    check("nt_rerr", resolve_error, 1);
    check("nt_rerr_nowrite", bht_write, 0);
    check("nt_rerr_bcnt", branch_count, 2);
    idle();
    check("nt_rerr_pulse", resolve_error, 0);

    // Taken mispredict
    push(16'h3000, 1'b0);
    resolve(1'b1, 16'h3100);
    check("tk_misp", mispredict, 1);
    check("tk_redirect", redirect_pc, 16'h3100);
    check("tk_taken", bht_taken, 1);
    check("tk_pc", bht_write_pc, 16'h3000);
    check("tk_mcnt", mispredict_count, 2);
    check("tk_bcnt", branch_count, 3);
    idle();

    // Full boundary
    push(16'h4000, 1'b1);
    push(16'h4002, 1'b1);
    push(16'h4004, 1'b1);
    check("f_notfull3", full, 0);
    push(16'h4006, 1'b1);
    check("f_full4", full, 1);
    push(16'h4008, 1'b1);  // ignored
    check("f_full5", full, 1);
    step(1'b1, 16'h400A, 1'b1, 1'b1, 1'b1, 16'h0);
    check("f_pp_full", full, 1);
    check("f_pp_pc", bht_write_pc, 16'h4000);
    check("f_pp_misp", mispredict, 0);
    resolve(1'b1, 16'h0);
    check("f_r1_pc", bht_write_pc, 16'h4002);
    check("f_r1_full", full, 0);
    resolve(1'b1, 16'h0);
    check("f_r2_pc", bht_write_pc, 16'h4004);
    resolve(1'b1, 16'h0);
    check("f_r3_pc", bht_write_pc, 16'h4006);
    resolve(1'b1, 16'h0);
    check("f_r4_pc", bht_write_pc, 16'h400A);
    check("f_r4_bhtw", bht_write, 1);
    check("f_bcnt", branch_count, 8);
    resolve(1'b1, 16'h0);
    check("f_empty_rerr", resolve_error, 1);
    idle();

    // Fall-through redirect wraps at 16 bits
    push(16'hFFFE, 1'b1);
    resolve(1'b0, 16'h1234);
    check("w_misp", mispredict, 1);
    check("w_redirect", redirect_pc, 16'h0000);
    check("w_mcnt", mispredict_count, 3);
    idle();

    // Branch counter wraps
    force dut.r_branch_count = 16'hFFFF;
    #1;
    release dut.r_branch_count;
    push(16'h5000, 1'b0);
    check("bc_preset", branch_count, 16'hFFFF);
    resolve(1'b0, 16'h0);
    check("bc_wrap", branch_count, 16'h0000);
    check("bc_wrap_misp", mispredict, 0);
    idle();

    // Asynchronous reset mid-operation drops pending write and records
    push(16'h6000, 1'b1);
    push(16'h6002, 1'b1);
    resolve(1'b1, 16'h0);
    check("ar_bhtw_pre", bht_write, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_bhtw", bht_write, 0);
    check("ar_pc", bht_write_pc, 0);
    check("ar_bcnt", branch_count, 0);
    check("ar_mcnt", mispredict_count, 0);
    check("ar_redirect", redirect_pc, 0);
    check("ar_full", full, 0);
    @(negedge clk);
    reset = 1'b0;
    resolve(1'b1, 16'h0);
    check("ar_discard_rerr", resolve_error, 1);
    check("ar_discard_bhtw", bht_write, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
